// File: rtl/cipher_tx_streamer.sv
// Streams a completed ciphertext buffer out as one UART frame:
// length header, data bytes read through a synchronous read port,
// then an optional XOR checksum byte.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for Start; Start latches the clamped length
// HDR     | header byte on Tx_Data, Tx_Send held until a fresh busy rise
// FETCH   | Rd_Addr presented for the current index
// LOAD    | Rd_Data valid; byte captured into Tx_Data and checksum
// SEND    | data/checksum byte held with Tx_Send until a fresh busy rise
// WAIT_HI | one cycle after the sender took the byte
// WAIT_LO | waiting for Tx_Busy to fall before the next byte
// CSUM    | checksum byte loaded into Tx_Data
// FIN     | one-cycle Done pulse, Busy already low
module cipher_tx_streamer #(
  parameter int MAX_LEN     = 100,
  parameter bit APPEND_CSUM = 1'b1
) (
  input  logic       Clk_100M,
  input  logic       Reset,
  input  logic       Start,
  input  logic [7:0] Length,
  output logic [7:0] Rd_Addr,
  input  logic [7:0] Rd_Data,
  output logic [7:0] Tx_Data,
  output logic       Tx_Send,
  input  logic       Tx_Busy,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] Checksum
);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_FETCH, S_LOAD, S_SEND, S_WAIT_HI, S_WAIT_LO, S_CSUM, S_FIN
  } state_t;

  // which byte of the frame is currently in flight
  typedef enum logic [1:0] {K_HDR, K_DATA, K_CSUM} kind_t;

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t     state_q, state_d;
  kind_t      kind_q, kind_d;
  logic [7:0] len_q, len_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] rd_addr_q, rd_addr_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_send_q, tx_send_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] csum_q, csum_d;
  logic       busy_prev_q, busy_prev_d;

  logic       busy_rise;
  logic [7:0] len_clamped;

  // A byte is only taken once busy rises while we hold Tx_Send; a busy level
  // left over from an earlier transfer must fall and rise again first.
  assign busy_rise   = Tx_Busy && !busy_prev_q;
  assign len_clamped = (Length > MAX_LEN_B) ? MAX_LEN_B : Length;

  // Next-state and datapath updates for the frame sequencer
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    len_d       = len_q;
    idx_d       = idx_q;
    rd_addr_d   = rd_addr_q;
    tx_data_d   = tx_data_q;
    tx_send_d   = tx_send_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    csum_d      = csum_q;
    busy_prev_d = Tx_Busy;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          len_d     = len_clamped;
          idx_d     = 8'd0;
          csum_d    = 8'd0;
          busy_d    = 1'b1;
          tx_data_d = len_clamped;
          tx_send_d = 1'b1;
          kind_d    = K_HDR;
          state_d   = S_HDR;
        end
      end
      S_HDR, S_SEND: begin
        if (busy_rise) begin
          tx_send_d = 1'b0;
          state_d   = S_WAIT_HI;
        end
      end
      S_WAIT_HI: state_d = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!Tx_Busy) begin
          case (kind_q)
            K_HDR: begin
              if (len_q == 8'd0) begin
                state_d = APPEND_CSUM ? S_CSUM : S_FIN;
              end else begin
                rd_addr_d = idx_q;
                state_d   = S_FETCH;
              end
            end
            K_DATA: begin
              if (idx_q == len_q - 8'd1) begin
                state_d = APPEND_CSUM ? S_CSUM : S_FIN;
              end else begin
                idx_d     = idx_q + 8'd1;
                rd_addr_d = idx_q + 8'd1;
                state_d   = S_FETCH;
              end
            end
            default: state_d = S_FIN;
          endcase
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        tx_data_d = Rd_Data;
        csum_d    = csum_q ^ Rd_Data;
        tx_send_d = 1'b1;
        kind_d    = K_DATA;
        state_d   = S_SEND;
      end
      S_CSUM: begin
        tx_data_d = csum_q;
        tx_send_d = 1'b1;
        kind_d    = K_CSUM;
        state_d   = S_SEND;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Busy drops and Done pulses on the same edge that enters FIN
    if (state_d == S_FIN && state_q != S_FIN) begin
      done_d = 1'b1;
      busy_d = 1'b0;
    end
  end

  // State and datapath registers; reset abandons any frame in progress
  always_ff @(posedge Clk_100M or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      kind_q      <= K_HDR;
      len_q       <= 8'd0;
      idx_q       <= 8'd0;
      rd_addr_q   <= 8'd0;
      tx_data_q   <= 8'd0;
      tx_send_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      csum_q      <= 8'd0;
      busy_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      rd_addr_q   <= rd_addr_d;
      tx_data_q   <= tx_data_d;
      tx_send_q   <= tx_send_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      csum_q      <= csum_d;
      busy_prev_q <= busy_prev_d;
    end
  end

  assign Rd_Addr  = rd_addr_q;
  assign Tx_Data  = tx_data_q;
  assign Tx_Send  = tx_send_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Checksum = csum_q;

endmodule
